seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Physical-display end of the display-selection path. Consumes the selected 32-bit display word, the 8-bit per-digit blink enables and the 8-bit per-digit decimal points.
- Time-multiplexes them onto an 8-digit common-anode seven-segment display: one digit lit at a time, hex decode, blink and anti-ghost blanking.
- Inputs are snapshotted once per full scan frame, so digits never tear mid-frame.

Parameters:
- SCAN_CYCLES, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 2000: cycles at the start of each slot with all anodes off; must be < SCAN_CYCLES.
- BLINK_CYCLES, 25000000: clock cycles per blink half-period.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- disp_num  in  32  display word; digit i shows nibble disp_num[4i+3:4i] (digit 0 rightmost).
- LE  in  8  LE[i]=1: digit i blinks.
- point  in  8  point[i]=1: decimal point of digit i lit.
- an  out  8  anode enables, active-low, an[i] drives digit i.
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (rst=0 at a rising edge):
  - an=8'hFF, seg=8'hFF, frame_done=0.
  - Slot counter cnt=0, digit index dig=0.
  - Blink counter=0, blink_phase=0.
  - Shadow registers (num_s, le_s, pt_s) = 0, so the first frame after reset displays "00000000" with no dp and no blink.
- Reset mid-frame: the same values apply on the next edge; there is no partial completion.
- Slot counter: cnt increments each cycle and wraps SCAN_CYCLES-1 → 0. On the wrap, dig increments modulo 8 (7 → 0).
- Snapshot: on the edge where cnt==SCAN_CYCLES-1 and dig==7:
  - num_s←disp_num, le_s←LE, pt_s←point, dig←0, frame_done←1 for exactly that following cycle.
  - Input changes at any other time have no visible effect until the next snapshot.
- Blink: the blink counter wraps at BLINK_CYCLES-1 and toggles blink_phase on the wrap. It runs independently of the scan.
- Outputs are registered and reflect the cnt/dig/shadow values of the previous cycle (1-cycle latency). Let n = num_s nibble for dig.
  - If cnt < BLANK_CYCLES: an=8'hFF, seg=8'hFF.
  - Else if le_s[dig]=1 and blink_phase=1: an=8'hFF, seg=8'hFF.
  - Else: an = ~(8'b1<<dig); seg[7] = ~pt_s[dig]; seg[6:0] = HEX(n).
- At most one an bit is ever low.
- HEX table ({g..a}, active-low):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Simultaneous blink toggle and snapshot: both take effect; the blink state applies to the new shadow from the next cycle.
- Frame period = 8·SCAN_CYCLES cycles. frame_done pulses exactly once per frame.

Test Plan:
All tests use SCAN_CYCLES=4, BLANK_CYCLES=1, BLINK_CYCLES=64.
- Reset: hold rst=0 for 3 cycles with disp_num=32'h12345678 → an=FF, seg=FF, frame_done=0. After release, the first frame shows all digits seg=8'hC0 (zeros).
- Snapshot and decode: disp_num=32'h89ABCDEF, point=0, LE=0. After the first frame_done, digit 0 shows seg=8'h8E (F) with an=8'hFE; digit 7 shows seg=8'h80 (8) with an=8'h7F. an=FF in the first cycle of every slot.
- Tear-free: change disp_num to 32'h0 mid-frame → the current frame still shows 89ABCDEF. The new value appears only after the next frame_done; frame_done recurs every 32 cycles.
- Decimal point: point=8'h01, disp_num=32'h00000005 → digit 0 seg=8'h12; all other digits seg=8'hC0.
- Blink: LE=8'h04 → digit 2 has an=FF and seg=FF during blink_phase=1 (64-cycle windows). It is normal in the alternate windows; other digits are unaffected.
- Reset mid-frame: assert rst at cnt=2, dig=5 → outputs FF next cycle. Scanning restarts at dig=0 and the shadow is zeroed.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display word in, multiplexed anode/segment drive out
interface seg7_scan_driver_if;
   logic [31:0] disp_num;
   logic [7:0]  LE;
   logic [7:0]  point;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        frame_done;

   modport master (
      output disp_num, LE, point,
      input  an, seg, frame_done
   );

   modport slave (
      input  disp_num, LE, point,
      output an, seg, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit common-anode seven-segment scanner with blink and blanking
module seg7_scan_driver #(
   parameter int SCAN_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 2000,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_driver_if.slave   bus
);

   localparam int CW = $clog2(SCAN_CYCLES);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] CNT_BLANK  = CW'(BLANK_CYCLES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic [2:0]    dig;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [31:0]   num_s;
   logic [7:0]    le_s;
   logic [7:0]    pt_s;
   logic [7:0]    an_q;
   logic [7:0]    seg_q;
   logic          frame_done_q;

   logic          slot_end;
   logic          frame_end;
   logic [31:0]   num_shift;
   logic [3:0]    nib;
   logic [7:0]    an_nxt;
   logic [7:0]    seg_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      slot_end  = (cnt == CNT_LAST);
      frame_end = slot_end && (dig == 3'd7);
      num_shift = num_s >> {dig, 2'b00};
      nib       = num_shift[3:0];
      an_nxt    = 8'hFF;
      seg_nxt   = 8'hFF;
      // Anti-ghost window at slot start, then suppress blinking digits in the off phase
      if ((cnt >= CNT_BLANK) && !(le_s[dig] && blink_phase)) begin
         an_nxt  = ~(8'b1 << dig);
         seg_nxt = {~pt_s[dig], hex7(nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt          <= '0;
         dig          <= 3'd0;
         blink_cnt    <= '0;
         blink_phase  <= 1'b0;
         num_s        <= 32'h0;
         le_s         <= 8'h0;
         pt_s         <= 8'h0;
         an_q         <= 8'hFF;
         seg_q        <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end) begin
            dig <= dig + 3'd1;
         end
         // Shadows only move at the frame boundary so a frame never shows a mix of words
         if (frame_end) begin
            num_s <= bus.disp_num;
            le_s  <= bus.LE;
            pt_s  <= bus.point;
         end
         frame_done_q <= frame_end;

         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         an_q  <= an_nxt;
         seg_q <= seg_nxt;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver against a cycle-index model
module tb_seg7_scan_driver;
   localparam int S  = 4;
   localparam int BL = 1;
   localparam int BK = 64;
   localparam int FRAME = 8 * S;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       fd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   seg7_scan_driver_if bus();

   seg7_scan_driver #(
      .SCAN_CYCLES  (S),
      .BLANK_CYCLES (BL),
      .BLINK_CYCLES (BK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          fd_seen = 0;
   int          fd_exp = 0;
   int          k = 0;
   logic [31:0] m_num = 32'h0;
   logic [7:0]  m_le = 8'h0;
   logic [7:0]  m_pt = 8'h0;
   logic [6:0]  hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Output after the k-th post-reset edge reflects scan position k
   function automatic exp_t model_out(int kk);
      int         cnt;
      int         d;
      int         ph;
      logic [3:0] n;
      exp_t       e;
      cnt = kk % S;
      d   = (kk / S) % 8;
      ph  = (kk / BK) % 2;
      n   = m_num[4*d +: 4];
      e.an  = 8'hFF;
      e.seg = 8'hFF;
      e.fd  = ((kk % FRAME) == FRAME - 1);
      if (cnt >= BL && !(m_le[d] && ph == 1)) begin
         e.an  = ~(8'h01 << d);
         e.seg = {~m_pt[d], hex_tab[n]};
      end
      return e;
   endfunction

   task automatic cycle();
      exp_t e;
      if (!rst) begin
         e = '{an: 8'hFF, seg: 8'hFF, fd: 1'b0};
         exp_q.push_back(e);
         k     = 0;
         m_num = 32'h0;
         m_le  = 8'h0;
         m_pt  = 8'h0;
      end else begin
         e = model_out(k);
         exp_q.push_back(e);
         if (e.fd) fd_exp++;
         if ((k % FRAME) == FRAME - 1) begin
            m_num = bus.disp_num;
            m_le  = bus.LE;
            m_pt  = bus.point;
         end
         k++;
      end
      @(negedge clk);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic randomize_inputs();
      bus.disp_num = $urandom();
      bus.LE       = 8'($urandom_range(0, 255));
      bus.point    = 8'($urandom_range(0, 255));
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.an !== e.an || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
            errors++;
            $display("FAIL outputs t=%0t: an=%h seg=%h fd=%b, required an=%h seg=%h fd=%b",
                     $time, bus.an, bus.seg, bus.frame_done, e.an, e.seg, e.fd);
         end
         checks++;
         if ($countones(~bus.an) > 1) begin
            errors++;
            $display("FAIL one_anode t=%0t: an=%h, required at most one low bit", $time, bus.an);
         end
         if (bus.frame_done === 1'b1) fd_seen++;
      end
   end

   initial begin
      bus.disp_num = 32'h12345678;
      bus.LE       = 8'h00;
      bus.point    = 8'h00;
      rst          = 1'b0;
      run(3);

      rst          = 1'b1;
      bus.disp_num = 32'h89ABCDEF;
      run(2 * FRAME);

      run(15);
      bus.disp_num = 32'h0;
      run(FRAME - 15 + 2 * FRAME);

      bus.point    = 8'h01;
      bus.disp_num = 32'h00000005;
      run(70);

      bus.point    = 8'h00;
      bus.LE       = 8'h04;
      bus.disp_num = 32'h76543210;
      run(200);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) randomize_inputs();
         cycle();
      end

      for (int i = 0; i < 2 * FRAME && (k % FRAME) != 5 * S + 2; i++) cycle();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      randomize_inputs();
      run(3 * FRAME);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) randomize_inputs();
         rst = ($urandom_range(0, 199) != 0);
         cycle();
      end
      rst = 1'b1;
      run(FRAME);

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d, required 0", exp_q.size());
      end
      checks++;
      if (fd_seen != fd_exp) begin
         errors++;
         $display("FAIL frame_done_count: got=%0d, required %0d", fd_seen, fd_exp);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
